// File: rtl/lsu_pkg.sv
// Shared constants and helpers for the load/store unit: funct3 codes, FSM
// state encoding and access-size decode.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[1:0] size codes
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC1 = 2'd1;
  localparam logic [1:0] ST_ACC2 = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ACC1 = ST_ACC1,
    ACC2 = ST_ACC2,
    RESP = ST_RESP
  } state_t;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 4'b0001;
      SZ_H:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Truncates a merged load word to the access size and sign/zero-extends it.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] merged,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic sign_b;
  logic sign_h;

  assign sign_b = ~is_unsigned & merged[7];
  assign sign_h = ~is_unsigned & merged[15];

  always_comb begin
    result = merged;
    case (size)
      SZ_B:    result = {{24{sign_b}}, merged[7:0]};
      SZ_H:    result = {{16{sign_h}}, merged[15:0]};
      default: result = merged;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and RAM port 1: splits word-crossing
// accesses into two RAM cycles, merges/extends load data, flags faults.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int SIZE_WORDS = 2**12,
  parameter int ADDR_WIDTH = $clog2(4*SIZE_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_fault,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wenable,
  input  logic [31:0]           mem_rdata
);

  localparam logic [32:0] ADDR_LIMIT = 33'(4*SIZE_WORDS);

  state_t                  state_reg, state_next;
  logic                    write_reg;
  logic [1:0]              size_reg;
  logic                    unsigned_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [31:0]             wdata_reg;
  logic                    fault_reg;
  logic                    cross_reg;
  logic [31:0]             data_reg;

  // Request decode, evaluated in IDLE and latched on accept
  logic [2:0]  req_bytes;
  logic [32:0] req_last_byte;
  logic        req_fault;
  logic        req_cross;

  assign req_bytes     = size_bytes(req_funct3[1:0]);
  assign req_last_byte = {1'b0, req_addr} + 33'(req_bytes) - 33'd1;
  assign req_fault     = (req_funct3 inside {3'b011, 3'b110, 3'b111})
                       | (req_write & req_funct3[2])
                       | (|(req_addr >> ADDR_WIDTH))
                       | (req_last_byte >= ADDR_LIMIT);
  assign req_cross     = ({1'b0, req_addr[1:0]} + req_bytes) > 3'd4;

  // n = bytes available in the first word from the offset onwards
  logic [2:0]            lane_n;
  logic [3:0]            lane_mask;
  logic [31:0]           lane_mask32;
  logic [5:0]            lane_shift;
  logic [ADDR_WIDTH-3:0] word_next;
  logic [31:0]           ext_data;
  logic [3:0]            wenable_comb;

  assign lane_n     = 3'd4 - {1'b0, addr_reg[1:0]};
  assign lane_mask  = 4'((5'd1 << lane_n) - 5'd1);
  assign lane_shift = {lane_n, 3'b000};
  assign word_next  = addr_reg[ADDR_WIDTH-1:2] + (ADDR_WIDTH-2)'(1);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane_mask
      assign lane_mask32[8*gi +: 8] = {8{lane_mask[gi]}};
    end
  endgenerate

  load_extend u_load_extend (
    .merged      (data_reg),
    .size        (size_reg),
    .is_unsigned (unsigned_reg),
    .result      (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      write_reg    <= 1'b0;
      size_reg     <= 2'b00;
      unsigned_reg <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      fault_reg    <= 1'b0;
      cross_reg    <= 1'b0;
      data_reg     <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            write_reg    <= req_write;
            size_reg     <= req_funct3[1:0];
            unsigned_reg <= req_funct3[2];
            addr_reg     <= req_addr[ADDR_WIDTH-1:0];
            wdata_reg    <= req_wdata;
            fault_reg    <= req_fault;
            cross_reg    <= req_cross & ~req_fault;
            data_reg     <= '0;
          end
        end
        ACC1:    data_reg <= mem_rdata & lane_mask32;
        ACC2:    data_reg <= data_reg | (mem_rdata << lane_shift);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next   = state_reg;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    resp_fault   = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    wenable_comb = 4'b0000;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = ACC1;
      end
      ACC1: begin
        mem_addr  = addr_reg;
        mem_wdata = wdata_reg;
        if (write_reg && !fault_reg) wenable_comb = size_mask(size_reg) & lane_mask;
        state_next = cross_reg ? ACC2 : RESP;
      end
      ACC2: begin
        mem_addr  = {word_next, 2'b00};
        mem_wdata = wdata_reg >> lane_shift;
        if (write_reg) wenable_comb = size_mask(size_reg) >> lane_n;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_fault = fault_reg;
        resp_rdata = (fault_reg || write_reg) ? 32'h0 : ext_data;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset must block a write even when it lands mid-access
  assign mem_wenable = wenable_comb & {4{~rst}};

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word RAM whose read
// data is returned pre-shifted by the byte offset.
module tb_load_store_unit;

  localparam int SIZE_WORDS = 2**12;
  localparam int ADDR_WIDTH = $clog2(4*SIZE_WORDS);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  req_valid = 1'b0;
  logic                  req_ready;
  logic                  req_write = 1'b0;
  logic [2:0]            req_funct3 = 3'b000;
  logic [31:0]           req_addr = 32'h0;
  logic [31:0]           req_wdata = 32'h0;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_fault;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wenable;
  logic [31:0]           mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.SIZE_WORDS(SIZE_WORDS), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_fault  (resp_fault),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wenable (mem_wenable),
    .mem_rdata   (mem_rdata)
  );

  // Behavioural RAM model
  logic [31:0] ram [0:SIZE_WORDS-1];
  logic [ADDR_WIDTH-3:0] ram_idx;
  logic [1:0] ram_off;
  assign ram_idx   = mem_addr[ADDR_WIDTH-1:2];
  assign ram_off   = mem_addr[1:0];
  assign mem_rdata = ram[ram_idx] >> {ram_off, 3'b000};

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (mem_wenable[k] && (int'(ram_off) + k) < 4)
        ram[ram_idx][(int'(ram_off) + k)*8 +: 8] <= mem_wdata[8*k +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd,
                         output logic flt, output int lat, output logic we_any);
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    lat = 0;
    we_any = 1'b0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      if (|mem_wenable) we_any = 1'b1;
    end while (!resp_valid && lat < 8);
    rd  = resp_rdata;
    flt = resp_fault;
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;
    logic        exp_we;
  } vec_t;

  vec_t vec [0:18];

  logic [31:0] rd;
  logic        flt;
  int          lat;
  logic        we_any;
  logic [5:0]  rdy_seen, rv_seen;
  logic [31:0] b2b_data;
  logic        rv_after;

  initial begin
    for (int i = 0; i < SIZE_WORDS; i++) ram[i] = 32'h0;
    ram[0] = 32'h8899AABB;
    ram[1] = 32'h11223344;

    vec[0]  = '{1'b0, 3'b010, 32'h0,        32'h0,        32'h8899AABB, 1'b0, 2, 1'b0};
    vec[1]  = '{1'b0, 3'b000, 32'h1,        32'h0,        32'hFFFFFFAA, 1'b0, 2, 1'b0};
    vec[2]  = '{1'b0, 3'b100, 32'h1,        32'h0,        32'h000000AA, 1'b0, 2, 1'b0};
    vec[3]  = '{1'b0, 3'b101, 32'h2,        32'h0,        32'h00008899, 1'b0, 2, 1'b0};
    vec[4]  = '{1'b0, 3'b001, 32'h2,        32'h0,        32'hFFFF8899, 1'b0, 2, 1'b0};
    vec[5]  = '{1'b0, 3'b010, 32'h2,        32'h0,        32'h33448899, 1'b0, 3, 1'b0};
    vec[6]  = '{1'b0, 3'b101, 32'h3,        32'h0,        32'h00004488, 1'b0, 3, 1'b0};
    vec[7]  = '{1'b0, 3'b000, 32'h7,        32'h0,        32'h00000011, 1'b0, 2, 1'b0};
    vec[8]  = '{1'b0, 3'b010, 32'(4*SIZE_WORDS-2), 32'h0, 32'h0,        1'b1, 2, 1'b0};
    vec[9]  = '{1'b1, 3'b100, 32'h8,        32'hFFFFFFFF, 32'h0,        1'b1, 2, 1'b0};
    vec[10] = '{1'b0, 3'b011, 32'h0,        32'h0,        32'h0,        1'b1, 2, 1'b0};
    vec[11] = '{1'b0, 3'b010, 32'h80000000, 32'h0,        32'h0,        1'b1, 2, 1'b0};
    vec[12] = '{1'b0, 3'b000, 32'(4*SIZE_WORDS-1), 32'h0, 32'h0,        1'b0, 2, 1'b0};
    vec[13] = '{1'b1, 3'b000, 32'h9,        32'h1234565A, 32'h0,        1'b0, 2, 1'b1};
    vec[14] = '{1'b0, 3'b100, 32'h9,        32'h0,        32'h0000005A, 1'b0, 2, 1'b0};
    vec[15] = '{1'b1, 3'b010, 32'hC,        32'h12345678, 32'h0,        1'b0, 2, 1'b1};
    vec[16] = '{1'b0, 3'b001, 32'hE,        32'h0,        32'h00001234, 1'b0, 2, 1'b0};
    vec[17] = '{1'b0, 3'b010, 32'h8,        32'h0,        32'h00005A00, 1'b0, 2, 1'b0};
    vec[18] = '{1'b1, 3'b110, 32'h10,       32'h55555555, 32'h0,        1'b1, 2, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'h1);
    chk("reset_resp_valid", 32'(resp_valid), 32'h0);
    chk("reset_resp_rdata", resp_rdata, 32'h0);
    chk("reset_resp_fault", 32'(resp_fault), 32'h0);
    chk("reset_mem_wenable", 32'(mem_wenable), 32'h0);
    chk("reset_mem_addr", 32'(mem_addr), 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    // Table-driven single requests
    for (int i = 0; i < 19; i++) begin
      run_req(vec[i].w, vec[i].f3, vec[i].addr, vec[i].wdata, rd, flt, lat, we_any);
      $display("vec %0d: w=%0d f3=%b addr=%h wdata=%h -> rdata=%h fault=%0d lat=%0d we=%0d",
               i, vec[i].w, vec[i].f3, vec[i].addr, vec[i].wdata, rd, flt, lat, we_any);
      chk($sformatf("vec%0d_rdata", i), rd, vec[i].exp_rdata);
      chk($sformatf("vec%0d_fault", i), 32'(flt), 32'(vec[i].exp_fault));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vec[i].exp_lat));
      chk($sformatf("vec%0d_wenable_seen", i), 32'(we_any), 32'(vec[i].exp_we));
    end
    chk("fault_store_no_write_word4", ram[4], 32'h0);

    // SH at 0x3 crossing into word1
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h3; req_wdata = 32'h0000CAFE;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("sh_acc1_addr", 32'(mem_addr), 32'h3);
    chk("sh_acc1_wen", 32'(mem_wenable), 32'h1);
    chk("sh_acc1_wdata", 32'(mem_wdata[7:0]), 32'hFE);
    @(negedge clk);
    chk("sh_acc2_addr", 32'(mem_addr), 32'h4);
    chk("sh_acc2_wen", 32'(mem_wenable), 32'h1);
    chk("sh_acc2_wdata", 32'(mem_wdata[7:0]), 32'hCA);
    @(negedge clk);
    chk("sh_resp_valid", 32'(resp_valid), 32'h1);
    chk("sh_resp_fault", 32'(resp_fault), 32'h0);
    chk("sh_resp_rdata", resp_rdata, 32'h0);
    chk("sh_word0", ram[0], 32'hFE99AABB);
    chk("sh_word1", ram[1], 32'h112233CA);
    $display("seq SH 0x3 wdata=0000cafe -> word0=%h word1=%h", ram[0], ram[1]);

    run_req(1'b0, 3'b010, 32'h3, 32'h0, rd, flt, lat, we_any);
    $display("seq LW 0x3 -> rdata=%h fault=%0d lat=%0d", rd, flt, lat);
    chk("lw3_rdata", rd, 32'h2233CAFE);
    chk("lw3_latency", 32'(lat), 32'd3);
    chk("lw3_fault", 32'(flt), 32'h0);

    // SW aborted by reset during ACC1
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h4; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_wenable", 32'(mem_wenable), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ready_after", 32'(req_ready), 32'h1);
    rv_after = resp_valid;
    repeat (3) begin
      @(negedge clk);
      rv_after = rv_after | resp_valid;
    end
    chk("rst_mid_no_resp", 32'(rv_after), 32'h0);
    chk("rst_mid_word1", ram[1], 32'h112233CA);
    $display("seq SW 0x4 with reset in ACC1 -> word1=%h resp_seen=%0d", ram[1], rv_after);

    // Back-to-back requests with req_valid held high
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0; req_wdata = 32'h0;
    @(posedge clk);
    b2b_data = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rdy_seen[i] = req_ready;
      rv_seen[i]  = resp_valid;
      if (i == 4) b2b_data = resp_rdata;
      if (i == 5) req_valid = 1'b0;
    end
    $display("seq back-to-back LW 0x0 -> ready=%b resp_valid=%b rdata2=%h",
             rdy_seen, rv_seen, b2b_data);
    chk("b2b_ready_pattern", 32'(rdy_seen), 32'b100100);
    chk("b2b_resp_pattern", 32'(rv_seen), 32'b010010);
    chk("b2b_second_rdata", b2b_data, 32'hFE99AABB);
    repeat (2) @(negedge clk);
    chk("b2b_idle_ready", 32'(req_ready), 32'h1);
    chk("b2b_idle_no_resp", 32'(resp_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
